// File: rtl/mux_2to1_demux.sv
// Receive-side demux for the shared 1-bit link: steers each accepted bit to one of
// two channel engines, deserializes LSB-first into WIDTH-bit words, and presents them on valid/ready ports.
//
// Per-channel output state machine:
//   state | meaning
//   EMPTY | no unconsumed word in the output register
//   FULL  | output register holds a word awaiting ready
module mux_2to1_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             select,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [1:0]       overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {EMPTY, FULL} ostate_t;

    logic [WIDTH-1:0] sh_q    [2];
    logic [CW-1:0]    cnt_q   [2];
    logic [WIDTH-1:0] out_q   [2];
    ostate_t          state_q [2];
    ostate_t          state_d [2];
    logic [1:0]       ovr_q;

    logic [WIDTH-1:0] word [2];
    logic [1:0]       accept;
    logic [1:0]       complete;
    logic [1:0]       ready;
    logic [1:0]       load;
    logic [1:0]       drop;

    always_comb begin
        ready  = {out1_ready, out0_ready};
        accept = {in_valid & select, in_valid & ~select};
        for (int k = 0; k < 2; k++) begin
            word[k]     = {in, sh_q[k][WIDTH-1:1]};
            complete[k] = accept[k] && (cnt_q[k] == LAST);
        end
    end

    // A completion while FULL reloads only if the consumer takes the old word on the same edge.
    always_comb begin
        load = 2'b00;
        drop = 2'b00;
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                EMPTY: begin
                    if (complete[k]) begin
                        load[k]    = 1'b1;
                        state_d[k] = FULL;
                    end
                end
                FULL: begin
                    if (complete[k]) begin
                        if (ready[k]) load[k] = 1'b1;
                        else          drop[k] = 1'b1;
                    end else if (ready[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                sh_q[k]    <= '0;
                cnt_q[k]   <= '0;
                out_q[k]   <= '0;
                state_q[k] <= EMPTY;
            end
            ovr_q <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (accept[k]) begin
                    sh_q[k]  <= word[k];
                    cnt_q[k] <= complete[k] ? '0 : cnt_q[k] + 1'b1;
                end
                if (load[k]) out_q[k] <= word[k];
                if (drop[k]) ovr_q[k] <= 1'b1;
                state_q[k] <= state_d[k];
            end
        end
    end

    assign out0       = out_q[0];
    assign out1       = out_q[1];
    assign out0_valid = (state_q[0] == FULL);
    assign out1_valid = (state_q[1] == FULL);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_mux_2to1_demux.sv
// Bench for mux_2to1_demux: directed scenarios plus randomized traffic, all
// checked every cycle against a word-level model of the two channels.
module tb_mux_2to1_demux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in, select, in_valid, out0_ready, out1_ready;
    logic [W-1:0] out0, out1;
    logic         out0_valid, out1_valid;
    logic [1:0]   overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    mux_2to1_demux #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in(in), .select(select), .in_valid(in_valid),
        .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Model: each channel accumulates bits arithmetically by position, then
    // hands a finished word to a one-deep output slot.
    int           m_n   [2];
    logic [W-1:0] m_acc [2];
    logic [W-1:0] m_out [2];
    logic         m_val [2];
    logic [1:0]   m_ovr;

    always @(posedge clk) begin
        int           c;
        int           done_ch;
        logic [W-1:0] done_word;
        logic         rdy [2];
        rdy[0] = out0_ready;
        rdy[1] = out1_ready;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_n[k] = 0; m_acc[k] = '0; m_out[k] = '0; m_val[k] = 1'b0;
            end
            m_ovr = 2'b00;
        end else begin
            done_ch   = -1;
            done_word = '0;
            if (in_valid) begin
                c = select ? 1 : 0;
                m_acc[c] = m_acc[c] | (W'(in) << m_n[c]);
                m_n[c]   = m_n[c] + 1;
                if (m_n[c] == W) begin
                    done_word = m_acc[c];
                    done_ch   = c;
                    m_acc[c]  = '0;
                    m_n[c]    = 0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (done_ch == k) begin
                    if (!m_val[k] || rdy[k]) begin
                        m_out[k] = done_word;
                        m_val[k] = 1'b1;
                    end else begin
                        m_ovr[k] = 1'b1;
                    end
                end else if (m_val[k] && rdy[k]) begin
                    m_val[k] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out0",    32'(out0),       32'(m_out[0]));
            chk("model_out0_v",  32'(out0_valid), 32'(m_val[0]));
            chk("model_out1",    32'(out1),       32'(m_out[1]));
            chk("model_out1_v",  32'(out1_valid), 32'(m_val[1]));
            chk("model_overrun", 32'(overrun),    32'(m_ovr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic sel, input logic b);
        in_valid = 1'b1;
        select   = sel;
        in       = b;
        tick();
    endtask

    task automatic send_bits(input logic sel, input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(sel, w[i]);
    endtask

    logic [W-1:0] w0, w1;
    int nb;

    initial begin
        rst = 1'b1; in = 1'b0; select = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out0",    32'(out0), 32'h0);
        chk("rst_out1",    32'(out1), 32'h0);
        chk("rst_valid",   32'({out1_valid, out0_valid}), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // partial word, then reset with a bit offered on the same edge
        w0 = 8'h07;
        send_bits(1'b0, w0, 3);
        rst = 1'b1; in = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0;
        w0 = 8'h05;
        send_bits(1'b0, w0, W);
        in_valid = 1'b0;
        chk("single_out0",   32'(out0), 32'h05);
        chk("single_valid0", 32'(out0_valid), 32'h1);
        chk("single_valid1", 32'(out1_valid), 32'h0);

        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();

        w0 = 8'hA5; w1 = 8'h3C;
        for (int i = 0; i < W; i++) begin
            send_bit(1'b0, w0[i]);
            if (i == W - 1) chk("ilv_out0", 32'(out0), 32'hA5);
            send_bit(1'b1, w1[i]);
            if (i == W - 1) begin
                chk("ilv_out1",    32'(out1), 32'h3C);
                chk("ilv_overrun", 32'(overrun), 32'h0);
            end
        end
        in_valid = 1'b0;
        tick();

        w1 = 8'hFF;
        nb = 0;
        while (nb < W) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in       = 1'($urandom);
                select   = 1'($urandom);
                tick();
            end else begin
                send_bit(1'b1, w1[nb]);
                nb++;
                if (nb == W - 1) chk("gap_not_yet", 32'(out1_valid), 32'h0);
            end
        end
        in_valid = 1'b0;
        chk("gap_out1",   32'(out1), 32'hFF);
        chk("gap_valid1", 32'(out1_valid), 32'h1);
        tick();

        out0_ready = 1'b0;
        w0 = 8'h11; send_bits(1'b0, w0, W);
        w0 = 8'h22; send_bits(1'b0, w0, W);
        in_valid = 1'b0;
        chk("bp_out0",    32'(out0), 32'h11);
        chk("bp_valid0",  32'(out0_valid), 32'h1);
        chk("bp_overrun", 32'(overrun[0]), 32'h1);
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        chk("bp_drain_valid",   32'(out0_valid), 32'h0);
        chk("bp_drain_overrun", 32'(overrun[0]), 32'h1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        w0 = 8'h11; send_bits(1'b0, w0, W);
        w0 = 8'h33; send_bits(1'b0, w0, W - 1);
        out0_ready = 1'b1;
        send_bit(1'b0, w0[W-1]);
        in_valid = 1'b0;
        out0_ready = 1'b0;
        chk("simul_out0",    32'(out0), 32'h33);
        chk("simul_valid0",  32'(out0_valid), 32'h1);
        chk("simul_overrun", 32'(overrun[0]), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            select     = 1'($urandom);
            in         = 1'($urandom);
            out0_ready = ($urandom_range(0, 9) < 6);
            out1_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
